paddle_quad_ctrl: RTL and testbench

Clocked, parametrised successor to the combinational paddle_movement block. Takes NUM_PADDLES quadrature rotary-encoder pairs and synchronises and debounces each pair. Decodes the Gray-code direction per channel and keeps a saturating paddle Y position per channel. Feeds the game/render logic: p_y drives paddle drawing and collision, and reset_game comes from the score/serve FSM.

---
 rtl/paddle_pkg.sv | 39 +++
 rtl/paddle_quad_ctrl_if.sv | 24 ++
 rtl/quad_decoder.sv | 86 ++++++++
 rtl/paddle_quad_ctrl.sv | 93 +++++++++
 tb/tb_paddle_quad_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/paddle_pkg.sv
// Shared defaults, quadrature codes and direction encoding for the paddle controller.
// Latency: none (constants and a pure decode function).
// Backpressure: none.
package paddle_pkg;

    localparam int Y_WIDTH_DEF = 6;
    localparam int Y_MIN_DEF   = 0;
    localparam int Y_MAX_DEF   = 56;
    localparam int Y_RESET_DEF = 28;

    // Quadrature codes as {A,B}
    localparam logic [1:0] Q00 = 2'b00;
    localparam logic [1:0] Q10 = 2'b10;
    localparam logic [1:0] Q11 = 2'b11;
    localparam logic [1:0] Q01 = 2'b01;

    typedef logic [1:0] dir_t;
    localparam dir_t DIR_NONE = 2'd0;
    localparam dir_t DIR_UP   = 2'd1;
    localparam dir_t DIR_DOWN = 2'd2;
    localparam dir_t DIR_ERR  = 2'd3;

    // Up sequence (A leads B): 00->10->11->01->00. Any other single-bit
    // change is necessarily a step of the down sequence.
    function automatic dir_t quad_dir(input logic [1:0] prev, input logic [1:0] cur);
        dir_t d;
        if (prev == cur)
            d = DIR_NONE;
        else if ((prev ^ cur) == 2'b11)
            d = DIR_ERR;
        else if ((prev == Q00 && cur == Q10) || (prev == Q10 && cur == Q11) ||
                 (prev == Q11 && cur == Q01) || (prev == Q01 && cur == Q00))
            d = DIR_UP;
        else
            d = DIR_DOWN;
        return d;
    endfunction

endpackage

// File: rtl/paddle_quad_ctrl_if.sv
// Paddle controller bus: control/encoder inputs toward the controller, positions and pulses back.
// Latency: n/a (wiring only).
// Backpressure: none; all outputs are level/pulse, never stalled.
// master = game/encoder side, slave = paddle_quad_ctrl.
interface paddle_quad_ctrl_if
    import paddle_pkg::*;
#(
    parameter int NUM_PADDLES = 2,
    parameter int Y_WIDTH     = Y_WIDTH_DEF
);
    logic                           reset_game;
    logic                           enable;
    logic [NUM_PADDLES-1:0]         enc_a;
    logic [NUM_PADDLES-1:0]         enc_b;
    logic [NUM_PADDLES*Y_WIDTH-1:0] p_y;
    logic [NUM_PADDLES-1:0]         move_up;
    logic [NUM_PADDLES-1:0]         move_down;
    logic [NUM_PADDLES-1:0]         enc_err;

    modport master (output reset_game, enable, enc_a, enc_b,
                    input  p_y, move_up, move_down, enc_err);
    modport slave  (input  reset_game, enable, enc_a, enc_b,
                    output p_y, move_up, move_down, enc_err);
endinterface

// File: rtl/quad_decoder.sv
// One encoder channel: synchronise, debounce, decode Gray transitions, accumulate sub-count.
// Latency: filtered input changes at edge SYNC_STAGES+DEBOUNCE; step/err are combinational from it.
// Backpressure: none. Ports: clk/reset, reset_game/enable controls, raw enc_a/enc_b in, step_up/step_down/err out.
module quad_decoder
    import paddle_pkg::*;
#(
    parameter int COUNTS_PER_STEP = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE        = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic reset_game,
    input  logic enable,
    input  logic enc_a,
    input  logic enc_b,
    output logic step_up,
    output logic step_down,
    output logic err
);
    localparam int CW  = $clog2(DEBOUNCE + 1);
    localparam int SCW = $clog2(COUNTS_PER_STEP) + 2;
    localparam logic signed [SCW-1:0] SC_TOP = SCW'(COUNTS_PER_STEP - 1);
    localparam logic signed [SCW-1:0] SC_BOT = -SC_TOP;
    localparam logic signed [SCW-1:0] SC_ONE = SCW'(1);

    logic [SYNC_STAGES-1:0]  sync_a, sync_b;
    logic [1:0]              sync_ab, filt, prev;
    logic [CW-1:0]           cnt [2];
    logic signed [SCW-1:0]   sc;
    dir_t                    dir;

    assign sync_ab = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], enc_a};
            sync_b <= {sync_b[SYNC_STAGES-2:0], enc_b};
        end
    end

    // Per-bit filter: the DEBOUNCE-th consecutive differing cycle commits the new value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt   <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync_ab[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEBOUNCE - 1)) begin
                    filt[i] <= sync_ab[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign dir       = quad_dir(prev, filt);
    assign step_up   = enable && (dir == DIR_UP)   && (sc == SC_TOP);
    assign step_down = enable && (dir == DIR_DOWN) && (sc == SC_BOT);
    assign err       = (dir == DIR_ERR);

    // prev always tracks the filter so gating (enable/reset_game) never causes a spurious step later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= Q00;
            sc   <= '0;
        end else begin
            prev <= filt;
            if (reset_game || !enable)
                sc <= '0;
            else if (dir == DIR_UP)
                sc <= (sc == SC_TOP) ? '0 : sc + SC_ONE;
            else if (dir == DIR_DOWN)
                sc <= (sc == SC_BOT) ? '0 : sc - SC_ONE;
        end
    end

endmodule

// File: rtl/paddle_quad_ctrl.sv
// NUM_PADDLES quadrature decoders driving saturating paddle Y positions.
// Latency: p_y and pulses update at edge SYNC_STAGES+DEBOUNCE+1 after a stable raw change.
// Backpressure: none. Ports: clk, reset (async, active-high), bus (slave): controls/encoders in, p_y/pulses out.
module paddle_quad_ctrl
    import paddle_pkg::*;
#(
    parameter int NUM_PADDLES     = 2,
    parameter int Y_WIDTH         = Y_WIDTH_DEF,
    parameter int Y_MIN           = Y_MIN_DEF,
    parameter int Y_MAX           = Y_MAX_DEF,
    parameter int Y_RESET         = Y_RESET_DEF,
    parameter int STEP            = 1,
    parameter int COUNTS_PER_STEP = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE        = 4
) (
    input  logic               clk,
    input  logic               reset,
    paddle_quad_ctrl_if.slave  bus
);
    localparam int YW1 = Y_WIDTH + 1;

    logic [NUM_PADDLES-1:0] step_up, step_down, err;
    logic [NUM_PADDLES-1:0] move_up_q, move_down_q, enc_err_q;
    logic [Y_WIDTH-1:0]     y_q  [NUM_PADDLES];
    logic [Y_WIDTH-1:0]     up_y [NUM_PADDLES];
    logic [Y_WIDTH-1:0]     dn_y [NUM_PADDLES];
    logic [YW1-1:0]         ext  [NUM_PADDLES];
    logic [YW1-1:0]         sum  [NUM_PADDLES];

    for (genvar g = 0; g < NUM_PADDLES; g++) begin : g_ch
        quad_decoder #(
            .COUNTS_PER_STEP (COUNTS_PER_STEP),
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE        (DEBOUNCE)
        ) u_dec (
            .clk        (clk),
            .reset      (reset),
            .reset_game (bus.reset_game),
            .enable     (bus.enable),
            .enc_a      (bus.enc_a[g]),
            .enc_b      (bus.enc_b[g]),
            .step_up    (step_up[g]),
            .step_down  (step_down[g]),
            .err        (err[g])
        );
        assign bus.p_y[g*Y_WIDTH +: Y_WIDTH] = y_q[g];
    end

    // Saturating neighbours computed one bit wider so nothing can wrap.
    always_comb begin
        for (int i = 0; i < NUM_PADDLES; i++) begin
            ext[i]  = {1'b0, y_q[i]};
            sum[i]  = ext[i] + YW1'(STEP);
            up_y[i] = (sum[i] > YW1'(Y_MAX)) ? Y_WIDTH'(Y_MAX) : sum[i][Y_WIDTH-1:0];
            dn_y[i] = (ext[i] < YW1'(Y_MIN + STEP)) ? Y_WIDTH'(Y_MIN)
                                                     : Y_WIDTH'(ext[i] - YW1'(STEP));
        end
    end

    // reset_game outranks any step landing in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PADDLES; i++) y_q[i] <= Y_WIDTH'(Y_RESET);
            move_up_q   <= '0;
            move_down_q <= '0;
            enc_err_q   <= '0;
        end else begin
            move_up_q   <= '0;
            move_down_q <= '0;
            enc_err_q   <= '0;
            for (int i = 0; i < NUM_PADDLES; i++) begin
                if (bus.reset_game) begin
                    y_q[i] <= Y_WIDTH'(Y_RESET);
                end else begin
                    enc_err_q[i] <= err[i];
                    if (step_up[i] && (up_y[i] != y_q[i])) begin
                        y_q[i]       <= up_y[i];
                        move_up_q[i] <= 1'b1;
                    end else if (step_down[i] && (dn_y[i] != y_q[i])) begin
                        y_q[i]         <= dn_y[i];
                        move_down_q[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.move_up   = move_up_q;
    assign bus.move_down = move_down_q;
    assign bus.enc_err   = enc_err_q;

endmodule

// File: tb/tb_paddle_quad_ctrl.sv
// Scoreboard bench for paddle_quad_ctrl: stimulus queues expected pulses, a monitor pops and checks them.
// Latency: expected pulses land 7 edges after the phase that causes them.
// Backpressure: none.
module tb_paddle_quad_ctrl;
    localparam int NP = 2;
    localparam int YW = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    paddle_quad_ctrl_if #(.NUM_PADDLES(NP), .Y_WIDTH(YW)) bus();

    paddle_quad_ctrl #(.NUM_PADDLES(NP), .Y_WIDTH(YW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int         ch;
        logic [2:0] kind;   // {move_up, move_down, enc_err}
        int         y;
        int         cyc;
    } ev_t;

    ev_t sb[$];
    ev_t mon_e;
    logic [2:0] mon_k;
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int py(input int ch);
        return int'(bus.p_y[ch*YW +: YW]);
    endfunction

    // Monitor: every pulse must match the head of the scoreboard, including its cycle.
    always @(negedge clk) begin
        if (!reset) begin
            for (int ch = 0; ch < NP; ch++) begin
                mon_k = {bus.move_up[ch], bus.move_down[ch], bus.enc_err[ch]};
                if (mon_k != 3'b000) begin
                    if (sb.size() == 0) begin
                        chk($sformatf("unexpected_pulse_ch%0d", ch), int'(mon_k), 0);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("ev_channel", ch, mon_e.ch);
                        chk("ev_kind", int'(mon_k), int'(mon_e.kind));
                        chk("ev_p_y", py(ch), mon_e.y);
                        chk("ev_cycle", cyc, mon_e.cyc);
                    end
                end
            end
        end
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] mask, input logic [1:0] code);
        for (int ch = 0; ch < NP; ch++)
            if (mask[ch]) begin
                bus.enc_a[ch] = code[1];
                bus.enc_b[ch] = code[0];
            end
    endtask

    task automatic expect_ev(input int ch, input logic [2:0] kind, input int y);
        ev_t e;
        e.ch = ch; e.kind = kind; e.y = y; e.cyc = cyc + 7;
        sb.push_back(e);
    endtask

    // One full quadrature cycle on the masked channels; step[ch] says whether a pulse is due.
    task automatic quad_cycle(input logic [1:0] mask, input bit dn, input logic [1:0] step,
                              input int ey0, input int ey1);
        logic [1:0] useq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
        logic [1:0] dseq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
        for (int k = 0; k < 4; k++) begin
            drive(mask, dn ? dseq[k] : useq[k]);
            if (k == 3) begin
                if (step[0]) expect_ev(0, dn ? 3'b010 : 3'b100, ey0);
                if (step[1]) expect_ev(1, dn ? 3'b010 : 3'b100, ey1);
            end
            hold(10);
        end
    endtask

    task automatic rg_pulse();
        bus.reset_game = 1'b1;
        hold(1);
        bus.reset_game = 1'b0;
        hold(2);
    endtask

    initial begin
        #5ms;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int ny;
        bus.enc_a      = '0;
        bus.enc_b      = '0;
        bus.enable     = 1'b1;
        bus.reset_game = 1'b0;
        hold(3);
        chk("reset_p_y0", py(0), 28);
        chk("reset_p_y1", py(1), 28);
        chk("reset_pulses", int'({bus.move_up, bus.move_down, bus.enc_err}), 0);
        reset = 1'b0;
        hold(2);

        // 1: one up cycle on channel 0
        quad_cycle(2'b01, 1'b0, 2'b01, 29, 0);
        hold(5);
        chk("t1_p_y0", py(0), 29);
        chk("t1_p_y1", py(1), 28);

        // 2: three down cycles on channel 1
        for (int i = 0; i < 3; i++) quad_cycle(2'b10, 1'b1, 2'b10, 0, 27 - i);
        hold(5);
        chk("t2_p_y1", py(1), 25);
        chk("t2_p_y0", py(0), 29);

        // 3: saturation up then down
        rg_pulse();
        chk("t3_recentre", py(0), 28);
        for (int i = 0; i < 40; i++) begin
            ny = 28 + i + 1;
            quad_cycle(2'b01, 1'b0, {1'b0, ny <= 56}, (ny > 56) ? 56 : ny, 0);
        end
        chk("t3_sat_hi", py(0), 56);
        rg_pulse();
        for (int i = 0; i < 40; i++) begin
            ny = 28 - i - 1;
            quad_cycle(2'b01, 1'b1, {1'b0, ny >= 0}, (ny < 0) ? 0 : ny, 0);
        end
        chk("t3_sat_lo", py(0), 0);
        chk("t3_p_y1", py(1), 28);

        // 4: short glitch, then illegal jumps 00->11 and back
        bus.enc_a[0] = 1'b1;
        hold(3);
        bus.enc_a[0] = 1'b0;
        hold(20);
        chk("t4_glitch_p_y0", py(0), 0);
        chk("t4_glitch_pending", sb.size(), 0);
        drive(2'b01, 2'b11);
        expect_ev(0, 3'b001, 0);
        hold(10);
        drive(2'b01, 2'b00);
        expect_ev(0, 3'b001, 0);
        hold(10);
        chk("t4_err_p_y0", py(0), 0);

        // 5: reset_game mid-move
        drive(2'b01, 2'b10); hold(10);
        drive(2'b01, 2'b11); hold(10);
        drive(2'b01, 2'b01); hold(10);
        rg_pulse();
        chk("t5_p_y0", py(0), 28);
        chk("t5_p_y1", py(1), 28);
        drive(2'b01, 2'b00); hold(12);
        chk("t5_no_step", py(0), 28);
        rg_pulse();

        // 6: enable gating and simultaneous steps
        bus.enable = 1'b0;
        quad_cycle(2'b01, 1'b0, 2'b00, 0, 0);
        chk("t6_frozen", py(0), 28);
        bus.enable = 1'b1;
        hold(2);
        quad_cycle(2'b01, 1'b0, 2'b01, 29, 0);
        chk("t6_enabled", py(0), 29);
        quad_cycle(2'b11, 1'b0, 2'b11, 30, 29);
        chk("t6_both_y0", py(0), 30);
        chk("t6_both_y1", py(1), 29);

        hold(10);
        chk("final_pending", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
